fir_xifu_ex: RTL and testbench

FIR_XIFU_EX -- requirements
Module: fir_xifu_ex

---
 rtl/cv32e40x_pkg.sv | 25 ++
 rtl/fir_xifu_pkg.sv | 33 +++
 rtl/cv32e40x_if_xif.sv | 22 ++
 rtl/fir_xifu_ex.sv | 140 ++++++++++++++
 tb/tb_fir_xifu_ex.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_pkg.sv
// Subset of the core-side eXtension-interface types used by the FIR coprocessor:
// privilege levels and the memory request payload.
package cv32e40x_pkg;

  parameter int X_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [3:0]            be;
    logic [1:0]            attr;
    logic [31:0]           wdata;
  } x_mem_req_t;

endpackage

// File: rtl/fir_xifu_pkg.sv
// Instruction codes and pipeline-register types shared by the FIR coprocessor stages.
package fir_xifu_pkg;

  import cv32e40x_pkg::X_ID_WIDTH;

  typedef logic [2:0] fir_xifu_instr_t;

  localparam fir_xifu_instr_t INSTR_NONE     = 3'd0;
  localparam fir_xifu_instr_t INSTR_XFIRLW   = 3'd1;
  localparam fir_xifu_instr_t INSTR_XFIRSW   = 3'd2;
  localparam fir_xifu_instr_t INSTR_XFIRDOTP = 3'd3;

  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    fir_xifu_instr_t       instr;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [31:0]           op_a;
    logic [31:0]           op_b;
    logic [31:0]           op_c;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    fir_xifu_instr_t       instr;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [31:0]           result;
  } fir_xifu_ex2wb_t;

endpackage

// File: rtl/cv32e40x_if_xif.sv
// Memory-request channel of the eXtension interface (coprocessor drives requests).
interface cv32e40x_if_xif;

  import cv32e40x_pkg::*;

  logic       mem_valid;
  logic       mem_ready;
  x_mem_req_t mem_req;

  modport coproc_mem (
    output mem_valid,
    output mem_req,
    input  mem_ready
  );

  modport cpu_mem (
    input  mem_valid,
    input  mem_req,
    output mem_ready
  );

endinterface

// File: rtl/fir_xifu_ex.sv
// FIR coprocessor execute stage: 16-bit dual MAC for XFIRDOTP, memory request
// issue with post-increment address result for XFIRLW/XFIRSW.
module fir_xifu_ex
  import cv32e40x_pkg::*;
  import fir_xifu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  cv32e40x_if_xif.coproc_mem xif_mem_o,
  input  fir_xifu_id2ex_t id2ex_i,
  output logic            ready_o,
  input  logic            kill_i,
  output fir_xifu_ex2wb_t ex2wb_o
);

  typedef enum logic {
    EX_IDLE,
    EX_MEMREQ
  } ex_state_t;

  ex_state_t       state_q, state_d;
  fir_xifu_ex2wb_t ex2wb_q;
  fir_xifu_ex2wb_t pend_q;
  x_mem_req_t      req_q;

  logic            is_mem, is_sw, is_dotp;
  x_mem_req_t      new_req;
  fir_xifu_ex2wb_t mem_done, dotp_done, load_val;
  logic            load_en, latch_en;
  logic            mem_valid;
  x_mem_req_t      mem_req;
  logic signed [31:0] prod_lo, prod_hi;

  assign is_sw   = (id2ex_i.instr == INSTR_XFIRSW);
  assign is_mem  = (id2ex_i.instr == INSTR_XFIRLW) || is_sw;
  assign is_dotp = (id2ex_i.instr == INSTR_XFIRDOTP);

  // Each 16x16 signed product fits in 32 bits, so only the final sum wraps.
  assign prod_lo = $signed(id2ex_i.op_a[15:0])  * $signed(id2ex_i.op_b[15:0]);
  assign prod_hi = $signed(id2ex_i.op_a[31:16]) * $signed(id2ex_i.op_b[31:16]);

  always_comb begin
    new_req       = '0;
    new_req.id    = id2ex_i.id;
    new_req.addr  = id2ex_i.op_a;
    new_req.mode  = PRIV_LVL_M;
    new_req.we    = is_sw;
    new_req.size  = 3'b010;
    new_req.be    = 4'hF;
    new_req.wdata = is_sw ? id2ex_i.op_c : 32'h0;
  end

  always_comb begin
    mem_done        = '0;
    mem_done.valid  = 1'b1;
    mem_done.id     = id2ex_i.id;
    mem_done.instr  = id2ex_i.instr;
    mem_done.rd     = id2ex_i.rd;
    mem_done.rs1    = id2ex_i.rs1;
    mem_done.result = id2ex_i.op_a + id2ex_i.op_b;

    dotp_done        = mem_done;
    dotp_done.result = id2ex_i.op_c + $unsigned(prod_lo) + $unsigned(prod_hi);
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    mem_valid = 1'b0;
    mem_req   = '0;
    load_en   = 1'b0;
    load_val  = '0;
    latch_en  = 1'b0;

    unique case (state_q)
      EX_IDLE: begin
        ready_o = 1'b1;
        if (id2ex_i.valid && is_dotp) begin
          load_en  = 1'b1;
          load_val = dotp_done;
        end else if (id2ex_i.valid && is_mem) begin
          mem_valid = 1'b1;
          mem_req   = new_req;
          if (xif_mem_o.mem_ready) begin
            load_en  = 1'b1;
            load_val = mem_done;
          end else begin
            latch_en = 1'b1;
            state_d  = EX_MEMREQ;
          end
        end
      end
      EX_MEMREQ: begin
        mem_valid = 1'b1;
        mem_req   = req_q;
        if (xif_mem_o.mem_ready) begin
          load_en  = 1'b1;
          load_val = pend_q;
          state_d  = EX_IDLE;
        end
      end
      default: state_d = EX_IDLE;
    endcase

    // The request path is combinational from id2ex_i, so hold it quiet during reset.
    if (!rst_ni) begin
      ready_o   = 1'b1;
      mem_valid = 1'b0;
      mem_req   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EX_IDLE;
      ex2wb_q <= '0;
      pend_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      // A kill or the end of a one-cycle result pulse both retire the held slot.
      if (load_en) begin
        ex2wb_q <= load_val;
      end else if (kill_i || ex2wb_q.valid) begin
        ex2wb_q.valid <= 1'b0;
      end
      if (latch_en) begin
        req_q  <= new_req;
        pend_q <= mem_done;
      end
    end
  end

  assign xif_mem_o.mem_valid = mem_valid;
  assign xif_mem_o.mem_req   = mem_req;
  assign ex2wb_o             = ex2wb_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Self-checking bench for fir_xifu_ex: directed corner cases plus randomized
// traffic against a transaction-level reference model.
module tb_fir_xifu_ex;

  import cv32e40x_pkg::*;
  import fir_xifu_pkg::*;

  logic            clk;
  logic            rst_ni;
  fir_xifu_id2ex_t id2ex;
  logic            ready;
  logic            kill;
  fir_xifu_ex2wb_t ex2wb;

  cv32e40x_if_xif xif ();

  fir_xifu_ex dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .xif_mem_o (xif),
    .id2ex_i   (id2ex),
    .ready_o   (ready),
    .kill_i    (kill),
    .ex2wb_o   (ex2wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory ops accepted but not yet handshaken (never more than one).
  fir_xifu_id2ex_t outstanding[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic fir_xifu_id2ex_t mk(input fir_xifu_instr_t instr, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c,
                                         input logic [3:0] id, input logic [4:0] rd,
                                         input logic [4:0] rs1);
    fir_xifu_id2ex_t t;
    t.valid = 1'b1; t.instr = instr; t.op_a = a; t.op_b = b; t.op_c = c;
    t.id = id; t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  function automatic bit is_mem_op(input fir_xifu_instr_t i);
    return (i == INSTR_XFIRLW) || (i == INSTR_XFIRSW);
  endfunction

  function automatic logic [31:0] ref_result(input fir_xifu_id2ex_t t);
    longint acc;
    if (t.instr == INSTR_XFIRDOTP) begin
      acc = longint'(t.op_c)
          + longint'($signed(t.op_a[15:0]))  * longint'($signed(t.op_b[15:0]))
          + longint'($signed(t.op_a[31:16])) * longint'($signed(t.op_b[31:16]));
      return acc[31:0];
    end
    acc = longint'(t.op_a) + longint'(t.op_b);
    return acc[31:0];
  endfunction

  // Starts and ends 1 time unit after a rising edge; checks the request
  // channel mid-cycle and the registered result after the edge.
  task automatic cycle(input fir_xifu_id2ex_t in, input bit mready, input bit kl);
    fir_xifu_id2ex_t cur, fin;
    bit has_mem, done;
    id2ex = in;
    xif.mem_ready = mready;
    kill = kl;
    #2;
    has_mem = 1'b0;
    done    = 1'b0;
    cur     = '0;
    fin     = '0;
    if (outstanding.size() != 0) begin
      cur = outstanding[0];
      has_mem = 1'b1;
      check("ready_busy", 32'(ready), 32'd0);
    end else begin
      check("ready_idle", 32'(ready), 32'd1);
      if (in.valid && is_mem_op(in.instr)) begin
        cur = in;
        has_mem = 1'b1;
      end
    end
    check("mem_valid", 32'(xif.mem_valid), 32'(has_mem));
    if (has_mem) begin
      check("mem_addr", xif.mem_req.addr, cur.op_a);
      check("mem_we", 32'(xif.mem_req.we), 32'(cur.instr == INSTR_XFIRSW));
      check("mem_wdata", xif.mem_req.wdata, (cur.instr == INSTR_XFIRSW) ? cur.op_c : 32'h0);
      check("mem_id", 32'(xif.mem_req.id), 32'(cur.id));
      check("mem_be", 32'(xif.mem_req.be), 32'hF);
      check("mem_size", 32'(xif.mem_req.size), 32'd2);
      check("mem_mode", 32'(xif.mem_req.mode), 32'(PRIV_LVL_M));
      if (mready) begin
        done = 1'b1;
        fin  = cur;
        if (outstanding.size() != 0) void'(outstanding.pop_front());
      end else if (outstanding.size() == 0) begin
        outstanding.push_back(cur);
      end
    end else if (in.valid && in.instr == INSTR_XFIRDOTP) begin
      done = 1'b1;
      fin  = in;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(ex2wb.valid), 32'(done));
    if (done) begin
      check("out_result", ex2wb.result, ref_result(fin));
      check("out_id", 32'(ex2wb.id), 32'(fin.id));
      check("out_instr", 32'(ex2wb.instr), 32'(fin.instr));
      check("out_rd", 32'(ex2wb.rd), 32'(fin.rd));
      check("out_rs1", 32'(ex2wb.rs1), 32'(fin.rs1));
    end
  endtask

  initial begin
    fir_xifu_id2ex_t t, idle;
    idle = '0;
    rst_ni = 1'b0;
    kill = 1'b0;
    xif.mem_ready = 1'b0;
    id2ex = mk(INSTR_XFIRLW, 32'h1234, 32'h4, 32'h0, 4'd1, 5'd1, 5'd2);
    #3;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_mem_valid", 32'(xif.mem_valid), 32'd0);
    check("rst_mem_addr", xif.mem_req.addr, 32'h0);
    check("rst_out_valid", 32'(ex2wb.valid), 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    id2ex = idle;
    @(posedge clk);
    #1;

    // Dot products, including the wrap-around corner.
    cycle(mk(INSTR_XFIRDOTP, 32'h0002_0003, 32'h0004_0005, 32'd10, 4'd2, 5'd3, 5'd4), 1'b0, 1'b0);
    check("dotp_33", ex2wb.result, 32'd33);
    cycle(mk(INSTR_XFIRDOTP, 32'h8000_8000, 32'h8000_8000, 32'd0, 4'd3, 5'd5, 5'd6), 1'b0, 1'b0);
    check("dotp_wrap", ex2wb.result, 32'h8000_0000);

    // Load with immediate handshake.
    cycle(mk(INSTR_XFIRLW, 32'h1000, 32'd4, 32'h0, 4'd4, 5'd7, 5'd9), 1'b1, 1'b0);
    check("lw_postinc", ex2wb.result, 32'h1004);
    check("lw_rs1", 32'(ex2wb.rs1), 32'd9);

    // Store stalled 3 cycles, with a kill during the stall that must not cancel it.
    t = mk(INSTR_XFIRSW, 32'h2000, 32'd8, 32'hDEAD_BEEF, 4'd5, 5'd0, 5'd10);
    cycle(t, 1'b0, 1'b0);
    cycle(idle, 1'b0, 1'b1);
    cycle(idle, 1'b0, 1'b0);
    cycle(idle, 1'b1, 1'b0);
    check("sw_postinc", ex2wb.result, 32'h2008);
    cycle(idle, 1'b1, 1'b0);

    // Back-to-back at full throughput.
    cycle(mk(INSTR_XFIRDOTP, 32'hFFFF_0001, 32'h0002_FFFF, 32'd100, 4'd6, 5'd1, 5'd1), 1'b1, 1'b0);
    cycle(mk(INSTR_XFIRLW, 32'hFFFF_FFFC, 32'd8, 32'h0, 4'd7, 5'd2, 5'd2), 1'b1, 1'b0);
    check("lw_wrap", ex2wb.result, 32'h4);
    cycle(mk(INSTR_XFIRDOTP, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'hFFFF_FFFF, 4'd8, 5'd3, 5'd3), 1'b1, 1'b0);

    // Kill of a held result, then an unknown instruction that must be dropped.
    cycle(idle, 1'b1, 1'b1);
    cycle(mk(3'd5, 32'h3000, 32'd4, 32'h1, 4'd9, 5'd4, 5'd4), 1'b1, 1'b0);

    // Reset while a request is pending.
    cycle(mk(INSTR_XFIRSW, 32'h4000, 32'd4, 32'hCAFE_F00D, 4'd10, 5'd5, 5'd5), 1'b0, 1'b0);
    id2ex = mk(INSTR_XFIRLW, 32'h5000, 32'd4, 32'h0, 4'd11, 5'd6, 5'd6);
    xif.mem_ready = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("rstmid_mem_valid", 32'(xif.mem_valid), 32'd0);
    check("rstmid_out_valid", 32'(ex2wb.valid), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    check("rsthold_mem_valid", 32'(xif.mem_valid), 32'd0);
    rst_ni = 1'b1;
    outstanding.delete();
    id2ex = idle;
    #2;
    check("rstrel_ready", 32'(ready), 32'd1);
    check("rstrel_mem_valid", 32'(xif.mem_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rstrel_out_valid", 32'(ex2wb.valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      t.valid = ($urandom_range(0, 3) != 0);
      t.instr = fir_xifu_instr_t'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) t.instr = fir_xifu_instr_t'($urandom_range(1, 3));
      t.id    = 4'($urandom);
      t.rd    = 5'($urandom);
      t.rs1   = 5'($urandom);
      t.op_a  = $urandom;
      t.op_b  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : $urandom;
      t.op_c  = $urandom;
      cycle(t, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
